// File: rtl/nbout_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : nbout_accumulator
// Description : Per-lane partial-sum (NBout) store behind the fp16 adder tree.
//               Feeds the tree its running partial sum for the addressed
//               output neuron, captures the tree result, counts bricks per
//               neuron, and queues finished sums in an output FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module nbout_accumulator #(
  parameter int DATA_W      = 16,
  parameter int NUM_ENTRIES = 16,
  parameter int ADDR_W      = 4,
  parameter int CNT_W       = 8,
  parameter int OUT_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  cfg_num_bricks,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  output logic [DATA_W-1:0] tree_nbout,
  input  logic [DATA_W-1:0] tree_sum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int FC_W   = $clog2(OUT_DEPTH + 1);
  localparam int FIFO_W = ADDR_W + DATA_W;
  localparam logic [CNT_W:0]   ONE_EXT    = 1;
  localparam logic [FC_W-1:0]  DEPTH_CNT  = FC_W'(OUT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT  = PTR_W'(OUT_DEPTH - 1);

  // Per-entry accumulator state
  logic [DATA_W-1:0] acc_q [NUM_ENTRIES];
  logic [DATA_W-1:0] acc_d [NUM_ENTRIES];
  logic [CNT_W-1:0]  cnt_q [NUM_ENTRIES];
  logic [CNT_W-1:0]  cnt_d [NUM_ENTRIES];

  // Output FIFO state (circular buffer)
  logic [FIFO_W-1:0] mem_q [OUT_DEPTH];
  logic [FIFO_W-1:0] mem_d [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]   count_q, count_d;

  logic              accept;
  logic              last_brick;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  bricks_eff;
  logic [CNT_W-1:0]  cnt_sel;
  logic [FIFO_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake, last-brick detection and head view; the count comparison is
  // done one bit wider so a full-scale brick count never wraps.
  always_comb begin
    in_ready   = !clear && (count_q < DEPTH_CNT);
    accept     = in_valid && in_ready;
    bricks_eff = (cfg_num_bricks == '0) ? CNT_W'(1) : cfg_num_bricks;
    cnt_sel    = cnt_q[in_addr];
    last_brick = (({1'b0, cnt_sel} + ONE_EXT) == {1'b0, bricks_eff});
    push       = accept && last_brick;
    out_valid  = (count_q != '0);
    pop        = out_valid && out_ready;
    tree_nbout = (cnt_sel == '0) ? '0 : acc_q[in_addr];
    head       = mem_q[rd_ptr_q];
    out_addr   = out_valid ? head[FIFO_W-1:DATA_W] : '0;
    out_data   = out_valid ? head[DATA_W-1:0] : '0;
  end

  // Busy whenever any entry holds a partial accumulation
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (cnt_q[i] != '0) busy = 1'b1;
    end
  end

  // Next-state for per-entry accumulators and brick counters
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      if (last_brick) begin
        cnt_d[in_addr] = '0;
      end else begin
        acc_d[in_addr] = tree_sum;
        cnt_d[in_addr] = cnt_sel + CNT_W'(1);
      end
    end
    if (clear) begin
      for (int i = 0; i < NUM_ENTRIES; i++) cnt_d[i] = '0;
    end
  end

  // Next-state for the output FIFO; simultaneous push and pop keeps count
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_addr, tree_sum};
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + FC_W'(1);
      2'b01:   count_d = count_q - FC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      for (int j = 0; j < OUT_DEPTH; j++) begin
        mem_q[j] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/nbout_accumulator.md
Name: nbout_accumulator

Overview:
- Partial-sum (NBout) store directly downstream of the 16-input fp16 adder tree in each cnvlutin filter lane.
- Supplies the tree's in_nbout operand for the addressed output neuron, captures the tree's out_sum, and counts accumulated bricks per neuron.
- When a neuron has received all its bricks, its final sum goes through an output FIFO with valid/ready handshake toward the writeback stage.
- Does no fp arithmetic itself; the adder tree is combinational and sits between tree_nbout and tree_sum within one cycle.

Parameters:
- DATA_W, 16, fp16 word width.
- NUM_ENTRIES, 16, output neurons held per lane; must be a power of 2.
- ADDR_W, 4, log2(NUM_ENTRIES).
- CNT_W, 8, brick counter width.
- OUT_DEPTH, 4, output FIFO depth.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_num_bricks  in  CNT_W  bricks per neuron; value 0 is treated as 1; held stable while busy.
- clear  in  1  synchronous clear of all per-entry counters.
- in_valid  in  1  products for this brick are on the tree inputs.
- in_ready  out  1  block can accept this cycle.
- in_addr  in  ADDR_W  output-neuron entry for this brick.
- tree_nbout  out  DATA_W  to adder tree in_nbout.
- tree_sum  in  DATA_W  from adder tree out_sum.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_addr  out  ADDR_W  entry index of head.
- out_data  out  DATA_W  final sum of head.
- busy  out  1  any entry has cnt != 0.

Behaviour:
- Per-entry state: acc[e] (DATA_W) and cnt[e] (CNT_W).
- On reset: all cnt = 0, acc = 0, FIFO empty, out_valid = 0, out_addr = 0, out_data = 0, busy = 0.
- tree_nbout is combinational: 16'h0000 if cnt[in_addr] == 0, else acc[in_addr]. It is valid regardless of in_valid.
- in_ready = !clear && (fifo_count < OUT_DEPTH).
- accept = in_valid && in_ready.
- Let N = (cfg_num_bricks == 0) ? 1 : cfg_num_bricks.
- On accept, last brick (cnt[e] + 1 == N): push {e, tree_sum} into the FIFO, then cnt[e] <= 0. acc[e] is left unchanged and must not be relied on.
- On accept, not last: acc[e] <= tree_sum, cnt[e] <= cnt[e] + 1.
- Counter compare is done at CNT_W + 1 bits, so N = 2^CNT_W - 1 works without wrap.
- Latency: an accept on the last brick makes the result visible at the FIFO head (out_valid = 1) on the next cycle if the FIFO was empty. Otherwise it is visible after earlier entries drain, in strict FIFO order.
- Pop occurs when out_valid && out_ready. out_addr and out_data are registered head values, held stable while out_valid && !out_ready.
- Push and pop in the same cycle: fifo_count unchanged, data ordering preserved.
- When full: in_ready = 0, so no push. A pop that cycle frees a slot, and in_ready rises on the next cycle because it is computed from the registered count.
- clear: all cnt <= 0 and busy drops the next cycle. in_ready = 0 during clear, so no accept. The FIFO is not flushed and pops continue normally.
- Accepts to different entries may interleave in any order; each entry accumulates independently.
- Asynchronous reset mid-accumulation drops all partial sums and FIFO contents immediately. tree_nbout reads 0000 after reset.
- busy = OR of (cnt[e] != 0) over all entries, registered-state derived.

Test Plan:
- cfg=3, entry 2; three accepts with tree_sum 3C00, 4000, 4200 -> tree_nbout reads 0000, 3C00, 4000 on the three accept cycles. One cycle after the third accept: out_valid=1, out_addr=2, out_data=4200. busy is 1 after the first accept and 0 after the third.
- cfg=2; interleave entry 0 (sums 3800, 3C00) and entry 1 (sums 4000, 4400) as 0, 1, 0, 1 -> tree_nbout reads 0000, 0000, 3800, 4000. Outputs in order: (0, 3C00) then (1, 4400).
- cfg=1 (and separately cfg=0), out_ready=0; five in_valid bricks to entries 0..4 -> the first four are accepted and in_ready goes low. The fifth is held until one pop, then accepted. Pops return addresses 0, 1, 2, 3, 4.
- FIFO at count 3, in_valid completing an entry and out_ready=1 in the same cycle -> count stays 3 and the head advances correctly.
- cfg=4; two bricks to entry 5, then clear pulse -> busy=0 next cycle. A subsequent brick to entry 5 sees tree_nbout=0000, and that entry completes only after 4 further bricks.
- Drop rst_n mid-accumulation with 2 FIFO entries pending -> out_valid=0 immediately, in_ready=1, busy=0, tree_nbout=0000 for every in_addr.
